ms_round_robin_source: RTL and testbench
========================================

# ms_round_robin_source

Round-robin master that drives three sync-qualified data channels (value plus one-cycle sync strobe) into a slave block. It also checks the slave's registered per-channel outputs against what it sent. The block is the initiating end of the master-slave test interface. It generates stimulus in the simulation and integration harness and flags mismatches for regression.

## Interface
Parameters:
- PERIOD, default 4: cycles from one slot's sync strobe to the next slot's sync strobe. Legal range is 3..255.
- STEP, default 1: signed increment added to a channel's counter after each send.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous and active-high; clears all state immediately
- en  input  1  run request; level-sensitive
- load  input  1  one-cycle pulse; loads base values (honoured only in IDLE)
- base_1, base_2, base_3  input  integer (32)  start values for channel counters
- m_out_1, m_out_2, m_out_3  output  integer (32)  channel data; reset value 0
- m_out_1_sync, m_out_2_sync, m_out_3_sync  output  1  one-cycle valid strobe per channel; reset value 0
- fb_1, fb_2, fb_3  input  integer (32)  slave's registered outputs for channels 1..3
- busy  output  1  high whenever state is not IDLE; reset value 0
- mismatch  output  1  sticky error flag; reset value 0
- err_count  output  integer (32)  number of failed checks, saturating at 2^31-1; reset value 0

## Operation
- States: IDLE, SLOT1, GAP1, SLOT2, GAP2, SLOT3, GAP3.
- IDLE:
  - load=1 copies base_k into counter cnt_k.
  - en=1 moves to SLOT1 on the next edge. If load and en are both high in the same cycle, the load applies first and the SLOT1 send uses the new bases.
- SLOTk (one cycle):
  - m_out_k_sync=1 and m_out_k=cnt_k.
  - At the edge, sent_k<=cnt_k and cnt_k<=cnt_k+STEP. The addition wraps modulo 2^32, two's complement.
  - Next state is GAPk.
- GAPk lasts PERIOD-1 cycles, counted by an 8-bit down-counter.
  - GAP1 goes to SLOT2 and GAP2 goes to SLOT3.
  - GAP3 goes to SLOT1 if en=1 in its last cycle, otherwise to IDLE.
  - Dropping en mid-round always completes the round through GAP3.
- load outside IDLE is ignored.
- m_out_k holds its last sent value between strobes. Only one sync strobe is high in any cycle.
- Check rule: the slave registers data on the sync edge. In the second cycle of GAPk, the block compares fb_k with sent_k.
  - On inequality: mismatch<=1 and err_count increments (saturating).
  - mismatch clears only on rst.
- Asserting rst in any state returns all outputs and state to their reset values. Any in-flight check is discarded, and cnt_k and sent_k clear to 0.

## Timing
- Latency is 1 cycle from en high in IDLE to the first m_out_1_sync.
- Strobe spacing is exactly PERIOD cycles. One full round is 3*PERIOD cycles.
- Checks sample fb_k two edges after m_out_k_sync. The slave's path must be registered with exactly one cycle of latency.
- busy rises on the edge leaving IDLE and falls on the edge entering IDLE.
- err_count and mismatch update one edge after the failing compare cycle.

## Test plan
- Reset and idle: hold rst for 3 cycles, then idle for 10. Required: all outputs stay 0, busy=0, and no sync strobe appears.
- Basic round: load base={10,20,30}, STEP=1, PERIOD=4, en held for 2 rounds, slave model echoing correctly.
  - Sync strobes occur at cycles 1, 5, 9, 13, 17, 21.
  - Data is 10, 20, 30, 11, 21, 31.
  - err_count=0 throughout.
- Wrap-around: base_1=32'h7FFFFFFF, STEP=1. Required: the second channel-1 send is 32'h80000000 with no error.
- Early en drop: deassert en during GAP1 of round 1. Required: SLOT2 and SLOT3 still fire, state returns to IDLE after GAP3, and busy falls.
- Mismatch: the slave model corrupts channel 2 once (returns 21 for a sent 20).
  - err_count=1 and mismatch=1, set one edge after the check cycle.
  - The flag stays set through later correct rounds.
- Reset mid-run and ignored load: pulse load with new bases during GAP2 and confirm counters are unchanged. Then assert rst during SLOT3.
  - All outputs are immediately 0 and state is IDLE.
  - After release with en=1, the first send is 0 because counters were cleared.

Source files
------------

// File: rtl/ms_round_robin_source_if.sv
// ms_round_robin_source_if
// Channel bundle between the round-robin master and the slave under test.
//   m_out_1..3       : channel data, master -> slave
//   m_out_1..3_sync  : one-cycle valid strobe per channel, master -> slave
//   fb_1..3          : slave's registered copy of each channel, slave -> master
interface ms_round_robin_source_if;
    logic [31:0] m_out_1;
    logic [31:0] m_out_2;
    logic [31:0] m_out_3;
    logic        m_out_1_sync;
    logic        m_out_2_sync;
    logic        m_out_3_sync;
    logic [31:0] fb_1;
    logic [31:0] fb_2;
    logic [31:0] fb_3;

    modport master (
        output m_out_1, m_out_2, m_out_3,
        output m_out_1_sync, m_out_2_sync, m_out_3_sync,
        input  fb_1, fb_2, fb_3
    );

    modport slave (
        input  m_out_1, m_out_2, m_out_3,
        input  m_out_1_sync, m_out_2_sync, m_out_3_sync,
        output fb_1, fb_2, fb_3
    );
endinterface

// File: rtl/ms_round_robin_source.sv
// ms_round_robin_source
// Round-robin master that sends three sync-qualified channels, one per slot,
// and checks the slave's registered feedback against what was sent.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : run request (level)
//   load       : copy base_1..3 into the channel counters (IDLE only)
//   base_1..3  : counter start values
//   bus        : master side of the channel bundle (data, strobes, feedback)
//   busy       : high whenever not IDLE
//   mismatch   : sticky feedback-error flag
//   err_count  : failed feedback checks, saturating at 2^31-1
//
// state | meaning
// IDLE  | waiting for en; load accepted here
// SLOT1 | strobe channel 1 with cnt_1
// GAP1  | PERIOD-1 cycles; channel 1 feedback checked in 2nd cycle
// SLOT2 | strobe channel 2 with cnt_2
// GAP2  | PERIOD-1 cycles; channel 2 feedback checked in 2nd cycle
// SLOT3 | strobe channel 3 with cnt_3
// GAP3  | PERIOD-1 cycles; channel 3 check; then SLOT1 if en else IDLE
module ms_round_robin_source #(
    parameter int unsigned PERIOD = 4,
    parameter int signed   STEP   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [31:0]                   base_1,
    input  logic [31:0]                   base_2,
    input  logic [31:0]                   base_3,
    ms_round_robin_source_if.master       bus,
    output logic                          busy,
    output logic                          mismatch,
    output logic [31:0]                   err_count
);

    typedef enum logic [2:0] {
        IDLE, SLOT1, GAP1, SLOT2, GAP2, SLOT3, GAP3
    } state_t;

    localparam logic [7:0]  GAP_LOAD = 8'(PERIOD - 2);
    // the check lands in the second gap cycle, i.e. one tick below the load value
    localparam logic [7:0]  CHK_AT   = 8'(PERIOD - 3);
    localparam logic [31:0] STEP_V   = 32'(STEP);
    localparam logic [31:0] ERR_MAX  = 32'h7FFF_FFFF;

    state_t      state, state_nx;
    logic [7:0]  gap_cnt;
    logic [31:0] cnt  [3];
    logic [31:0] sent [3];
    logic [31:0] base_v [3];
    logic [31:0] fb_v [3];
    logic [2:0]  slot_hit;
    logic        in_gap;
    logic [1:0]  chk_ch;
    logic        chk_fail;

    assign base_v[0] = base_1;
    assign base_v[1] = base_2;
    assign base_v[2] = base_3;
    assign fb_v[0]   = bus.fb_1;
    assign fb_v[1]   = bus.fb_2;
    assign fb_v[2]   = bus.fb_3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        slot_hit = 3'b000;
        in_gap   = 1'b0;
        chk_ch   = 2'd0;
        case (state)
            IDLE:  if (en) state_nx = SLOT1;
            SLOT1: begin slot_hit = 3'b001; state_nx = GAP1; end
            GAP1:  begin
                in_gap = 1'b1; chk_ch = 2'd0;
                if (gap_cnt == 8'd0) state_nx = SLOT2;
            end
            SLOT2: begin slot_hit = 3'b010; state_nx = GAP2; end
            GAP2:  begin
                in_gap = 1'b1; chk_ch = 2'd1;
                if (gap_cnt == 8'd0) state_nx = SLOT3;
            end
            SLOT3: begin slot_hit = 3'b100; state_nx = GAP3; end
            GAP3:  begin
                in_gap = 1'b1; chk_ch = 2'd2;
                if (gap_cnt == 8'd0) state_nx = en ? SLOT1 : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign chk_fail = in_gap && (gap_cnt == CHK_AT) && (fb_v[chk_ch] != sent[chk_ch]);

    // data is live from the counter during the slot, held from sent_k otherwise
    assign bus.m_out_1      = slot_hit[0] ? cnt[0] : sent[0];
    assign bus.m_out_2      = slot_hit[1] ? cnt[1] : sent[1];
    assign bus.m_out_3      = slot_hit[2] ? cnt[2] : sent[2];
    assign bus.m_out_1_sync = slot_hit[0];
    assign bus.m_out_2_sync = slot_hit[1];
    assign bus.m_out_3_sync = slot_hit[2];
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt   <= 8'd0;
            mismatch  <= 1'b0;
            err_count <= 32'd0;
            for (int k = 0; k < 3; k++) begin
                cnt[k]  <= 32'd0;
                sent[k] <= 32'd0;
            end
        end else begin
            if (slot_hit != 3'b000)  gap_cnt <= GAP_LOAD;
            else if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;

            if (state == IDLE && load) begin
                for (int k = 0; k < 3; k++) cnt[k] <= base_v[k];
            end

            for (int k = 0; k < 3; k++) begin
                if (slot_hit[k]) begin
                    sent[k] <= cnt[k];
                    cnt[k]  <= cnt[k] + STEP_V;
                end
            end

            if (chk_fail) begin
                mismatch <= 1'b1;
                if (err_count != ERR_MAX) err_count <= err_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ms_round_robin_source.sv
module tb_ms_round_robin_source;

    localparam int P = 4;
    localparam int S = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] base_1, base_2, base_3;
    logic        busy;
    logic        mismatch;
    logic [31:0] err_count;

    ms_round_robin_source_if bus ();

    ms_round_robin_source #(.PERIOD(P), .STEP(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .base_1    (base_1),
        .base_2    (base_2),
        .base_3    (base_3),
        .bus       (bus),
        .busy      (busy),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int corrupt_at = -1;

    // slave model: registers each channel on its sync edge, optionally corrupting one send
    always @(posedge clk) begin
        if (bus.m_out_1_sync) bus.fb_1 <= (cyc == corrupt_at) ? bus.m_out_1 + 32'd1 : bus.m_out_1;
        if (bus.m_out_2_sync) bus.fb_2 <= (cyc == corrupt_at) ? bus.m_out_2 + 32'd1 : bus.m_out_2;
        if (bus.m_out_3_sync) bus.fb_3 <= (cyc == corrupt_at) ? bus.m_out_3 + 32'd1 : bus.m_out_3;
        cyc <= cyc + 1;
    end

    // monitor: record every strobe as (cycle, channel, value)
    int          ev_cyc[$];
    int          ev_ch[$];
    logic [31:0] ev_val[$];
    int          multi_sync  = 0;
    int          err_chg_cyc = -1;
    logic [31:0] err_prev    = 32'd0;

    always @(negedge clk) begin
        int n;
        n = int'(bus.m_out_1_sync) + int'(bus.m_out_2_sync) + int'(bus.m_out_3_sync);
        if (n > 1) multi_sync = multi_sync + 1;
        if (bus.m_out_1_sync === 1'b1) begin ev_cyc.push_back(cyc); ev_ch.push_back(1); ev_val.push_back(bus.m_out_1); end
        if (bus.m_out_2_sync === 1'b1) begin ev_cyc.push_back(cyc); ev_ch.push_back(2); ev_val.push_back(bus.m_out_2); end
        if (bus.m_out_3_sync === 1'b1) begin ev_cyc.push_back(cyc); ev_ch.push_back(3); ev_val.push_back(bus.m_out_3); end
        if (err_count !== err_prev) err_chg_cyc = cyc;
        err_prev = err_count;
    end

    function automatic bit all_zero();
        return (bus.m_out_1 === 32'd0) && (bus.m_out_2 === 32'd0) && (bus.m_out_3 === 32'd0) &&
               (bus.m_out_1_sync === 1'b0) && (bus.m_out_2_sync === 1'b0) && (bus.m_out_3_sync === 1'b0) &&
               (busy === 1'b0) && (mismatch === 1'b0) && (err_count === 32'd0);
    endfunction

    // Runs nrounds rounds (en dropped during GAP1 of the last round) and checks the
    // strobe stream against the round-robin rule: send i is channel (i%3)+1 at cycle
    // c0+1+P*i carrying base + STEP*(i/3).
    task automatic run_and_check(input string name, input logic [31:0] b1, input logic [31:0] b2,
                                 input logic [31:0] b3, input int nrounds, input int corrupt_idx,
                                 input bit do_load, output int c0, output int first_ev);
        logic [31:0] mb [3];
        logic [31:0] err0, exp_err, exp_val;
        logic        mm0, exp_mm;
        int          ms0, t, exp_cyc, exp_ch;
        mb[0] = b1; mb[1] = b2; mb[2] = b3;
        @(negedge clk);
        first_ev = ev_cyc.size();
        err0 = err_count; mm0 = mismatch; ms0 = multi_sync;
        if (do_load) begin base_1 = b1; base_2 = b2; base_3 = b3; end
        else begin base_1 = 32'hDEAD_BEEF; base_2 = 32'hDEAD_BEEF; base_3 = 32'hDEAD_BEEF; end
        load = do_load; en = 1'b1; c0 = cyc;
        if (corrupt_idx >= 0) corrupt_at = c0 + 1 + P * corrupt_idx;
        @(negedge clk);
        load = 1'b0;
        while (cyc < c0 + 3 * P * (nrounds - 1) + 2) @(negedge clk);
        en = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
        corrupt_at = -1;
        checks++;
        if (t >= 200) begin
            failures++;
            $display("FAIL %s busy_timeout: busy=%b still high after %0d cycles, required 0", name, busy, t);
        end
        checks++;
        if (cyc !== c0 + 3 * P * nrounds + 1) begin
            failures++;
            $display("FAIL %s busy_fall: fell at rel cycle %0d, required %0d", name, cyc - c0, 3 * P * nrounds + 1);
        end
        checks++;
        if (ev_cyc.size() - first_ev !== 3 * nrounds) begin
            failures++;
            $display("FAIL %s send_count: got %0d strobes, required %0d", name, ev_cyc.size() - first_ev, 3 * nrounds);
        end
        for (int i = 0; i < 3 * nrounds; i++) begin
            exp_cyc = c0 + 1 + P * i;
            exp_ch  = (i % 3) + 1;
            exp_val = mb[i % 3] + 32'(S * (i / 3));
            checks++;
            if (first_ev + i >= ev_cyc.size()) begin
                failures++;
                $display("FAIL %s send%0d: missing, required ch%0d=%0h at rel %0d", name, i, exp_ch, exp_val, exp_cyc - c0);
            end else if (ev_cyc[first_ev + i] !== exp_cyc || ev_ch[first_ev + i] !== exp_ch ||
                         ev_val[first_ev + i] !== exp_val) begin
                failures++;
                $display("FAIL %s send%0d: got ch%0d=%0h at rel %0d, required ch%0d=%0h at rel %0d", name, i,
                         ev_ch[first_ev + i], ev_val[first_ev + i], ev_cyc[first_ev + i] - c0,
                         exp_ch, exp_val, exp_cyc - c0);
            end
        end
        exp_err = err0 + ((corrupt_idx >= 0) ? 32'd1 : 32'd0);
        exp_mm  = mm0 | (corrupt_idx >= 0);
        checks++;
        if (err_count !== exp_err || mismatch !== exp_mm) begin
            failures++;
            $display("FAIL %s errors: err_count=%0d mismatch=%b, required %0d %b", name, err_count, mismatch, exp_err, exp_mm);
        end
        checks++;
        if (multi_sync !== ms0) begin
            failures++;
            $display("FAIL %s onehot_sync: %0d cycles with >1 strobe, required 0", name, multi_sync - ms0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        base_1 = 32'd0; base_2 = 32'd0; base_3 = 32'd0;
        #1;
        checks++;
        if (!all_zero()) begin
            failures++;
            $display("FAIL reset_async: busy=%b mismatch=%b err=%0d sync=%b%b%b, required all 0", busy, mismatch,
                     err_count, bus.m_out_1_sync, bus.m_out_2_sync, bus.m_out_3_sync);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!all_zero()) begin
                failures++;
                $display("FAIL reset_idle%0d: busy=%b out1=%0h sync=%b%b%b, required all 0", i, busy, bus.m_out_1,
                         bus.m_out_1_sync, bus.m_out_2_sync, bus.m_out_3_sync);
            end
        end
    endtask

    task automatic test_basic_round();
        int c0, f;
        run_and_check("basic", 32'd10, 32'd20, 32'd30, 2, -1, 1'b1, c0, f);
        checks++;
        if (err_count !== 32'd0) begin
            failures++;
            $display("FAIL basic_err: err_count=%0d, required 0", err_count);
        end
    endtask

    task automatic test_random_rounds();
        int c0, f;
        for (int k = 0; k < 3; k++)
            run_and_check("random", $urandom, $urandom, $urandom, int'($urandom_range(1, 3)), -1, 1'b1, c0, f);
    endtask

    task automatic test_wrap();
        int c0, f;
        run_and_check("wrap", 32'h7FFF_FFFF, $urandom, 32'hFFFF_FFFF, 2, -1, 1'b1, c0, f);
        checks++;
        if (ev_val.size() <= f + 3 || ev_val[f + 3] !== 32'h8000_0000) begin
            failures++;
            $display("FAIL wrap_ch1: second ch1 send=%0h, required 80000000", (ev_val.size() > f + 3) ? ev_val[f + 3] : 32'hx);
        end
    endtask

    task automatic test_early_drop();
        int c0, f;
        run_and_check("early_drop", $urandom, $urandom, $urandom, 1, -1, 1'b1, c0, f);
    endtask

    task automatic test_mismatch();
        int c0, f;
        run_and_check("mismatch", 32'd10, 32'd20, 32'd30, 3, 1, 1'b1, c0, f);
        checks++;
        if (err_count !== 32'd1 || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_sticky: err_count=%0d mismatch=%b, required 1 1", err_count, mismatch);
        end
        // ch2 strobe at rel 5, check in rel 7, flag visible from rel 8
        checks++;
        if (err_chg_cyc !== c0 + 8) begin
            failures++;
            $display("FAIL mismatch_timing: err_count changed at rel %0d, required 8", err_chg_cyc - c0);
        end
    endtask

    task automatic test_reset_midrun();
        int c0, f;
        @(negedge clk);
        base_1 = 32'd100; base_2 = 32'd200; base_3 = 32'd300;
        load = 1'b1; en = 1'b1; c0 = cyc;
        @(negedge clk);
        load = 1'b0;
        while (cyc < c0 + 7) @(negedge clk);
        base_1 = 32'd555; base_2 = 32'd666; base_3 = 32'd777; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_out_3_sync !== 1'b1 || bus.m_out_3 !== 32'd300) begin
            failures++;
            $display("FAIL ignored_load: sync3=%b out3=%0d at rel %0d, required 1 300", bus.m_out_3_sync, bus.m_out_3, cyc - c0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!all_zero()) begin
            failures++;
            $display("FAIL reset_midrun: busy=%b mismatch=%b err=%0d out3=%0h sync3=%b, required all 0", busy,
                     mismatch, err_count, bus.m_out_3, bus.m_out_3_sync);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_and_check("post_reset", 32'd0, 32'd0, 32'd0, 1, -1, 1'b0, c0, f);
    endtask

    initial begin
        test_reset();
        test_basic_round();
        test_random_rounds();
        test_wrap();
        test_early_drop();
        test_mismatch();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
